fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction field splitter. Owns the program counter, issues word-aligned read requests to instruction memory, and buffers returned words in a small in-order queue. Presents each word with its PC over a valid/ready handshake; the presented instruction word drives the splitter's `inst` input. Branch/jump redirects from later stages flush queued and in-flight fetches.

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int              INST_W           = 32;
    localparam int              PC_W             = 32;
    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order queue of fetched {pc, inst} entries; flush beats push, and a pop may
// complete in the same cycle as a flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  fetch_entry_t                push_data_i,
    input  logic                        pop_i,
    output logic                        valid_o,
    output fetch_entry_t                head_o,
    output logic [$clog2(DEPTH+1)-1:0]  count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && !flush_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited memory requests, stale-response dropping
// after redirects, and an in-order output queue feeding the field splitter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int             CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
    logic             req_valid_q, req_valid_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] occupancy, occupancy_d;
    logic             req_fire, rsp_accept, rsp_live, pop;
    fetch_entry_t     head, push_entry;

    assign req_fire   = req_valid_q && imem_req_ready;
    assign rsp_accept = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_live   = rsp_accept && (drop_cnt_q == '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    // Live responses return in request order, so their PCs are consecutive from rsp_pc_q.
    assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (rsp_live),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .valid_o     (inst_valid),
        .head_o      (head),
        .count_o     (occupancy)
    );

    always_comb begin
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_accept);
        occupancy_d   = occupancy + CNT_W'(rsp_live) - CNT_W'(pop);
        if (req_fire) pc_d = pc_q + PC_INC;
        if (rsp_live) rsp_pc_d = rsp_pc_q + PC_INC;
        if (rsp_accept && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        if (redirect_valid) begin
            // Everything still in flight, including a request accepted this cycle, is stale.
            pc_d        = align_pc(redirect_pc);
            rsp_pc_d    = align_pc(redirect_pc);
            drop_cnt_d  = outstanding_d;
            occupancy_d = '0;
        end
        req_valid_d = ({1'b0, outstanding_d} + {1'b0, occupancy_d}) < CREDIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            req_valid_q   <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            req_valid_q   <= req_valid_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst           = inst_valid ? head.inst : '0;
    assign inst_pc        = inst_valid ? head.pc   : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with variable latency,
// per-request behavioural model compared every cycle, plus directed scenarios.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk, rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;

    logic        w_req_valid, w_inst_valid;
    logic [31:0] w_addr, w_inst, w_inst_pc;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(w_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst(w_inst), .inst_pc(w_inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // ---------------- memory model ----------------
    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t       pend[$];
    logic [31:0] addr_log[$];
    logic [31:0] waddr_log[$];
    int          lat_min = 1;
    int          lat_max = 1;

    initial begin : mem_proc
        int          cyc;
        int          due;
        logic        s_fire, s_wfire;
        logic [31:0] s_addr, s_waddr;
        cyc = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            s_fire  = rst_n && imem_req_valid && imem_req_ready;
            s_addr  = imem_addr;
            s_wfire = rst_n && w_req_valid && imem_req_ready;
            s_waddr = w_addr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
                continue;
            end
            cyc++;
            if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
            if (s_fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
                pend.push_back('{due: due, addr: s_addr});
                addr_log.push_back(s_addr);
            end
            if (s_wfire) waddr_log.push_back(s_waddr);
            imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc + 1);
            imem_rsp_data  = imem_rsp_valid ? mem_word(pend[0].addr) : '0;
        end
    end

    // ---------------- behavioural model + compare ----------------
    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;
    req_t        mouts[$];
    word_t       mq[$];
    logic [31:0] exp_pc;
    bit          alive;
    logic [31:0] dut_deliv[$];

    initial begin : model_proc
        bit   e_req, e_inst, fire, pop;
        req_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mouts.delete();
                mq.delete();
                exp_pc = 32'h0;
                alive  = 1'b0;
                check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
                check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
                check("rst_inst", inst, 32'd0);
                check("rst_inst_pc", inst_pc, 32'd0);
                continue;
            end
            e_req  = alive && (mouts.size() + mq.size() < DEPTH);
            e_inst = mq.size() > 0;
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
            check("imem_addr", imem_addr, exp_pc);
            check("inst_valid", {31'b0, inst_valid}, {31'b0, e_inst});
            check("inst", inst, e_inst ? mq[0].data : 32'h0);
            check("inst_pc", inst_pc, e_inst ? mq[0].pc : 32'h0);
            if (inst_valid && inst_ready) dut_deliv.push_back(inst_pc);

            fire = e_req && imem_req_ready;
            pop  = e_inst && inst_ready;
            if (pop) void'(mq.pop_front());
            if (imem_rsp_valid && mouts.size() > 0) begin
                r = mouts.pop_front();
                if (!r.stale && !redirect_valid) mq.push_back('{pc: r.pc, data: mem_word(r.pc)});
            end
            if (fire) begin
                mouts.push_back('{pc: exp_pc, stale: 1'b0});
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                foreach (mouts[i]) mouts[i].stale = 1'b1;
                mq.delete();
                exp_pc = {redirect_pc[31:2], 2'b00};
            end
            alive = 1'b1;
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin : stim
        int          n, mark, dmark, fires, breaks;
        logic [31:0] popped_pc;
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // first valid instruction three edges after release
        n = 0;
        while (!inst_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_valid_edge", n, 32'd3);
        repeat (12) @(posedge clk);
        #2;
        check("addr0", at(addr_log, 0), 32'h0000_0000);
        check("addr1", at(addr_log, 1), 32'h0000_0004);
        check("addr2", at(addr_log, 2), 32'h0000_0008);
        check("wrap_addr0", at(waddr_log, 0), 32'hFFFF_FFF8);
        check("wrap_addr1", at(waddr_log, 1), 32'hFFFF_FFFC);
        check("wrap_addr2", at(waddr_log, 2), 32'h0000_0000);

        // backpressure: stall downstream for 10 cycles
        mark = addr_log.size();
        dmark = dut_deliv.size();
        inst_ready = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        fires = addr_log.size() - mark;
        check("bp_at_most_depth_reqs", {31'b0, fires <= DEPTH}, 32'd1);
        check("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        check("bp_no_delivery", dut_deliv.size() - dmark, 32'd0);
        inst_ready = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        breaks = 0;
        for (int i = 1; i < dut_deliv.size(); i++)
            if (dut_deliv[i] != dut_deliv[i-1] + 32'd4) breaks++;
        check("bp_no_gap_dup", breaks, 32'd0);

        // redirect with two requests in flight on a 3-cycle memory
        lat_min = 3; lat_max = 3;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(pend.size() == 2 && !inst_valid) && n < 60);
        check("rd_two_in_flight", {31'b0, pend.size() == 2}, 32'd1);
        mark = addr_log.size();
        dmark = dut_deliv.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        check("rd_next_addr", at(addr_log, mark), 32'h0000_0100);
        check("rd_first_pc", at(dut_deliv, dmark), 32'h0000_0100);
        check("rd_second_pc", at(dut_deliv, dmark + 1), 32'h0000_0104);

        // redirect coinciding with a request handshake and a pop
        lat_min = 1; lat_max = 1;
        n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!(imem_req_valid && inst_valid) && n < 60);
        check("rpp_condition", {31'b0, imem_req_valid && inst_valid}, 32'd1);
        popped_pc = (mq.size() > 0) ? mq[0].pc : 32'hDEAD_BEEF;
        dmark = dut_deliv.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("rpp_popped_once", at(dut_deliv, dmark), popped_pc);
        check("rpp_new_stream", at(dut_deliv, dmark + 1), 32'h0000_0200);
        check("rpp_drop_cnt_zero", 32'(u_dut.drop_cnt_q), 32'd0);

        // randomized traffic with random latency, stalls and redirects
        lat_min = 1; lat_max = 4;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            imem_req_ready = ($urandom_range(9, 0) < 7);
            inst_ready = ($urandom_range(9, 0) < 6);
            if (redirect_valid) redirect_valid = 1'b0;
            else if ($urandom_range(99, 0) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom;
            end
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        inst_ready = 1'b1;
        lat_min = 1; lat_max = 1;
        repeat (10) @(posedge clk);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        check("async_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("async_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("async_inst", inst, 32'd0);
        check("async_inst_pc", inst_pc, 32'd0);
        check("async_addr", imem_addr, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        mark = addr_log.size();
        repeat (10) @(posedge clk);
        #2;
        check("restart_addr0", at(addr_log, mark), 32'h0000_0000);
        check("restart_addr1", at(addr_log, mark + 1), 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
